// File: rtl/paddle_ctrl_pkg.sv
// Shared pong definitions: playfield geometry used by the paddle, renderer
// and collision logic, the paddle FSM state encoding, and clamped step
// helpers for the paddle position.
package paddle_ctrl_pkg;

    localparam int Y_MAX    = 480;
    localparam int PADDLE_H = 64;
    localparam int Y_LIM    = Y_MAX - PADDLE_H;   // lowest legal top edge
    localparam int Y_CENTER = Y_LIM / 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MOVE_UP = 2'd1,
        MOVE_DN = 2'd2
    } paddle_state_e;

    // Move toward 0, clamping at the top wall. Done at 11 bits so the
    // comparison sees the true magnitude of the step.
    function automatic logic [9:0] step_up(input logic [9:0] y, input logic [10:0] step);
        logic [10:0] y11;
        logic [10:0] diff;
        y11  = {1'b0, y};
        diff = y11 - step;
        return (y11 < step) ? 10'd0 : diff[9:0];
    endfunction

    // Move toward Y_LIM, clamping at the bottom wall. The 11-bit sum cannot
    // wrap, so an overshoot is always caught by the compare.
    function automatic logic [9:0] step_dn(input logic [9:0] y, input logic [10:0] step);
        logic [10:0] sum;
        sum = {1'b0, y} + step;
        return (sum > 11'(Y_LIM)) ? 10'(Y_LIM) : sum[9:0];
    endfunction

endpackage

// File: rtl/paddle_ctrl_if.sv
// Paddle controller signal bundle.
//   up, down   : key levels from the keyboard decoder (asynchronous to clock)
//   center     : synchronous recentre request
//   paddle_y   : top edge of the paddle, 0..Y_LIM
//   moving     : paddle FSM is in a MOVE state
//   at_top     : paddle_y == 0
//   at_bottom  : paddle_y == Y_LIM
// master drives the requests and observes the position; slave is the
// controller.
interface paddle_ctrl_if;
    logic       up;
    logic       down;
    logic       center;
    logic [9:0] paddle_y;
    logic       moving;
    logic       at_top;
    logic       at_bottom;

    modport master (
        output up, down, center,
        input  paddle_y, moving, at_top, at_bottom
    );

    modport slave (
        input  up, down, center,
        output paddle_y, moving, at_top, at_bottom
    );
endinterface

// File: rtl/paddle_ctrl_tick_gen.sv
// Free-running divider producing a one-cycle tick every CLK_DIV clocks.
// Reusable for any fixed-rate motion update (paddle, ball).
//   clock  : system clock
//   resetn : asynchronous active-low reset, counter restarts at 0
//   tick   : high for the one cycle in which the counter wraps
module paddle_ctrl_tick_gen #(
    parameter int CLK_DIV = 500000
) (
    input  logic clock,
    input  logic resetn,
    output logic tick
);
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);
endmodule

// File: rtl/paddle_ctrl.sv
// Paddle position controller. Turns held up/down key levels into a paddle
// top-edge position, stepping once per movement tick, accelerating after
// ACCEL_TICKS consecutive ticks in the same direction, and clamping to the
// playfield.
//   clock  : system clock
//   resetn : asynchronous active-low reset
//   bus    : paddle_ctrl_if.slave (key levels, center in; position/flags out)
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | no command seen at the last tick (or centred / reset)
// MOVE_UP | up alone held at the last tick; paddle_y steps toward 0
// MOVE_DN | down alone held at the last tick; paddle_y steps toward Y_LIM
module paddle_ctrl
    import paddle_ctrl_pkg::*;
#(
    parameter int CLK_DIV     = 500000,
    parameter int STEP_SLOW   = 2,
    parameter int STEP_FAST   = 6,
    parameter int ACCEL_TICKS = 16
) (
    input  logic          clock,
    input  logic          resetn,
    paddle_ctrl_if.slave  bus
);
    localparam int HOLD_W = $clog2(ACCEL_TICKS + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(ACCEL_TICKS);
    localparam logic [10:0] STEP_S = 11'(STEP_SLOW);
    localparam logic [10:0] STEP_F = 11'(STEP_FAST);

    logic              tick;
    logic              up_s1, up_s2, dn_s1, dn_s2;
    paddle_state_e     state;
    logic [HOLD_W-1:0] hold_cnt;
    logic [9:0]        y_q;

    logic              cmd_up, cmd_dn, same_dir;
    logic [HOLD_W-1:0] hold_next;
    logic [10:0]       step;
    logic [9:0]        y_up, y_dn;

    paddle_ctrl_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clock  (clock),
        .resetn (resetn),
        .tick   (tick)
    );

    // Step size is chosen from the hold count this tick will leave behind,
    // so entering a direction always uses the slow step.
    always_comb begin
        cmd_up   = up_s2 & ~dn_s2;
        cmd_dn   = dn_s2 & ~up_s2;
        same_dir = (cmd_up && state == MOVE_UP) || (cmd_dn && state == MOVE_DN);
        hold_next = '0;
        if (same_dir) begin
            hold_next = (hold_cnt == HOLD_MAX) ? hold_cnt : hold_cnt + 1'b1;
        end
        step = (hold_next == HOLD_MAX) ? STEP_F : STEP_S;
        y_up = step_up(y_q, step);
        y_dn = step_dn(y_q, step);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            up_s1    <= 1'b0;
            up_s2    <= 1'b0;
            dn_s1    <= 1'b0;
            dn_s2    <= 1'b0;
            state    <= IDLE;
            hold_cnt <= '0;
            y_q      <= 10'(Y_CENTER);
        end else begin
            up_s1 <= bus.up;
            up_s2 <= up_s1;
            dn_s1 <= bus.down;
            dn_s2 <= dn_s1;

            // center wins over a coincident tick
            if (bus.center) begin
                state    <= IDLE;
                hold_cnt <= '0;
                y_q      <= 10'(Y_CENTER);
            end else if (tick) begin
                if (cmd_up) begin
                    state    <= MOVE_UP;
                    hold_cnt <= hold_next;
                    y_q      <= y_up;
                end else if (cmd_dn) begin
                    state    <= MOVE_DN;
                    hold_cnt <= hold_next;
                    y_q      <= y_dn;
                end else begin
                    state    <= IDLE;
                    hold_cnt <= '0;
                end
            end
        end
    end

    assign bus.paddle_y  = y_q;
    assign bus.moving    = (state != IDLE);
    assign bus.at_top    = (y_q == 10'd0);
    assign bus.at_bottom = (y_q == 10'(Y_LIM));
endmodule

// File: tb/tb_paddle_ctrl.sv
// Directed bench for paddle_ctrl with CLK_DIV=4, ACCEL_TICKS=3.
module tb_paddle_ctrl;
    import paddle_ctrl_pkg::*;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    int   n_cmp  = 0;
    int   n_bad  = 0;
    logic [1:0] ph;   // expected phase of the free-running 0..3 tick counter

    paddle_ctrl_if bus();

    paddle_ctrl #(
        .CLK_DIV     (4),
        .STEP_SLOW   (2),
        .STEP_FAST   (6),
        .ACCEL_TICKS (3)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    always @(posedge clock or negedge resetn) begin
        if (!resetn) ph <= 2'd0;
        else         ph <= ph + 2'd1;
    end

    // Advance to just after the n-th next tick edge.
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            while (ph != 2'd3) @(negedge clock);
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset();
        bus.up = 1'b0; bus.down = 1'b0; bus.center = 1'b0;
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        n_cmp++;
        if ({bus.paddle_y, bus.moving, bus.at_top, bus.at_bottom} !== {10'd208, 3'b000}) begin
            n_bad++;
            $display("FAIL reset_state got y=%0d mv=%b top=%b bot=%b want y=208 mv=0 top=0 bot=0",
                     bus.paddle_y, bus.moving, bus.at_top, bus.at_bottom);
        end
        resetn = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clock);
            n_cmp++;
            if ({bus.paddle_y, bus.moving, bus.at_top, bus.at_bottom} !== {10'd208, 3'b000}) begin
                n_bad++;
                $display("FAIL idle_cycle%0d got y=%0d mv=%b top=%b bot=%b want y=208 flags 000",
                         c, bus.paddle_y, bus.moving, bus.at_top, bus.at_bottom);
            end
        end
        wait_ticks(1);
    endtask

    task automatic test_accel();
        int exp_y [5] = '{206, 204, 202, 196, 190};
        bus.up = 1'b1;
        for (int t = 0; t < 5; t++) begin
            wait_ticks(1);
            n_cmp++;
            if (bus.paddle_y !== 10'(exp_y[t]) || bus.moving !== 1'b1) begin
                n_bad++;
                $display("FAIL accel_tick%0d got y=%0d mv=%b want y=%0d mv=1",
                         t + 1, bus.paddle_y, bus.moving, exp_y[t]);
            end
        end
        bus.up = 1'b0;
        for (int t = 0; t < 2; t++) begin
            wait_ticks(1);
            n_cmp++;
            if (bus.paddle_y !== 10'd190 || bus.moving !== 1'b0) begin
                n_bad++;
                $display("FAIL release_tick%0d got y=%0d mv=%b want y=190 mv=0",
                         t + 1, bus.paddle_y, bus.moving);
            end
        end
    endtask

    task automatic test_wall_top();
        int exp_y [4] = '{2, 0, 0, 0};
        bus.up = 1'b1;
        wait_ticks(33);
        n_cmp++;
        if (bus.paddle_y !== 10'd4) begin
            n_bad++;
            $display("FAIL top_approach got y=%0d want y=4", bus.paddle_y);
        end
        bus.up = 1'b0;
        wait_ticks(1);
        n_cmp++;
        if (bus.paddle_y !== 10'd4 || bus.moving !== 1'b0) begin
            n_bad++;
            $display("FAIL top_idle got y=%0d mv=%b want y=4 mv=0", bus.paddle_y, bus.moving);
        end
        bus.up = 1'b1;
        for (int t = 0; t < 4; t++) begin
            wait_ticks(1);
            n_cmp++;
            if (bus.paddle_y !== 10'(exp_y[t]) || bus.moving !== 1'b1 ||
                bus.at_top !== (exp_y[t] == 0)) begin
                n_bad++;
                $display("FAIL top_pin_tick%0d got y=%0d mv=%b top=%b want y=%0d mv=1 top=%b",
                         t + 1, bus.paddle_y, bus.moving, bus.at_top, exp_y[t], exp_y[t] == 0);
            end
        end
        bus.up = 1'b0; bus.down = 1'b1;
        wait_ticks(1);
        n_cmp++;
        if (bus.paddle_y !== 10'd2 || bus.at_top !== 1'b0 || bus.moving !== 1'b1) begin
            n_bad++;
            $display("FAIL top_reverse got y=%0d top=%b mv=%b want y=2 top=0 mv=1",
                     bus.paddle_y, bus.at_top, bus.moving);
        end
        wait_ticks(1);
        n_cmp++;
        if (bus.paddle_y !== 10'd4) begin
            n_bad++;
            $display("FAIL top_reverse2 got y=%0d want y=4", bus.paddle_y);
        end
    endtask

    task automatic test_wall_bottom();
        bus.down = 1'b0;
        wait_ticks(1);
        bus.down = 1'b1;
        wait_ticks(70);
        n_cmp++;
        if (bus.paddle_y !== 10'd412 || bus.at_bottom !== 1'b0) begin
            n_bad++;
            $display("FAIL bot_approach got y=%0d bot=%b want y=412 bot=0", bus.paddle_y, bus.at_bottom);
        end
        bus.down = 1'b0;
        wait_ticks(1);
        bus.down = 1'b1;
        wait_ticks(1);
        n_cmp++;
        if (bus.paddle_y !== 10'd414 || bus.at_bottom !== 1'b0) begin
            n_bad++;
            $display("FAIL bot_step1 got y=%0d bot=%b want y=414 bot=0", bus.paddle_y, bus.at_bottom);
        end
        for (int t = 0; t < 4; t++) begin
            wait_ticks(1);
            n_cmp++;
            if (bus.paddle_y !== 10'd416 || bus.at_bottom !== 1'b1 || bus.moving !== 1'b1) begin
                n_bad++;
                $display("FAIL bot_pin_tick%0d got y=%0d bot=%b mv=%b want y=416 bot=1 mv=1",
                         t + 1, bus.paddle_y, bus.at_bottom, bus.moving);
            end
        end
    endtask

    task automatic test_both_and_center();
        bus.up = 1'b1;
        for (int t = 0; t < 11; t++) begin
            wait_ticks(1);
            n_cmp++;
            if (bus.paddle_y !== 10'd416 || bus.moving !== 1'b0 || bus.at_bottom !== 1'b1) begin
                n_bad++;
                $display("FAIL both_keys_tick%0d got y=%0d mv=%b bot=%b want y=416 mv=0 bot=1",
                         t + 1, bus.paddle_y, bus.moving, bus.at_bottom);
            end
        end
        bus.up = 1'b0;
        wait_ticks(1);
        n_cmp++;
        if (bus.paddle_y !== 10'd416 || bus.moving !== 1'b1) begin
            n_bad++;
            $display("FAIL resume_dn got y=%0d mv=%b want y=416 mv=1", bus.paddle_y, bus.moving);
        end
        // center on the same edge as a tick
        @(negedge clock);
        while (ph != 2'd3) @(negedge clock);
        bus.center = 1'b1;
        @(posedge clock);
        #1;
        bus.center = 1'b0;
        n_cmp++;
        if (bus.paddle_y !== 10'd208 || bus.moving !== 1'b0 || bus.at_bottom !== 1'b0) begin
            n_bad++;
            $display("FAIL center_on_tick got y=%0d mv=%b bot=%b want y=208 mv=0 bot=0",
                     bus.paddle_y, bus.moving, bus.at_bottom);
        end
        wait_ticks(1);
        n_cmp++;
        if (bus.paddle_y !== 10'd210 || bus.moving !== 1'b1) begin
            n_bad++;
            $display("FAIL after_center got y=%0d mv=%b want y=210 mv=1", bus.paddle_y, bus.moving);
        end
        // center between ticks
        @(negedge clock);
        bus.center = 1'b1;
        @(posedge clock);
        #1;
        bus.center = 1'b0;
        n_cmp++;
        if (bus.paddle_y !== 10'd208 || bus.moving !== 1'b0) begin
            n_bad++;
            $display("FAIL center_off_tick got y=%0d mv=%b want y=208 mv=0", bus.paddle_y, bus.moving);
        end
        wait_ticks(1);
        n_cmp++;
        if (bus.paddle_y !== 10'd210 || bus.moving !== 1'b1) begin
            n_bad++;
            $display("FAIL after_center2 got y=%0d mv=%b want y=210 mv=1", bus.paddle_y, bus.moving);
        end
    endtask

    task automatic test_reset_mid_move();
        int exp_y [4] = '{212, 214, 220, 226};
        for (int t = 0; t < 4; t++) begin
            wait_ticks(1);
            n_cmp++;
            if (bus.paddle_y !== 10'(exp_y[t])) begin
                n_bad++;
                $display("FAIL premove_tick%0d got y=%0d want y=%0d", t + 1, bus.paddle_y, exp_y[t]);
            end
        end
        @(negedge clock);
        resetn = 1'b0;
        #1;
        n_cmp++;
        if ({bus.paddle_y, bus.moving, bus.at_top, bus.at_bottom} !== {10'd208, 3'b000}) begin
            n_bad++;
            $display("FAIL async_reset got y=%0d mv=%b top=%b bot=%b want y=208 flags 000",
                     bus.paddle_y, bus.moving, bus.at_top, bus.at_bottom);
        end
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        wait_ticks(1);
        n_cmp++;
        if (bus.paddle_y !== 10'd210 || bus.moving !== 1'b1) begin
            n_bad++;
            $display("FAIL post_reset_tick1 got y=%0d mv=%b want y=210 mv=1", bus.paddle_y, bus.moving);
        end
        wait_ticks(1);
        n_cmp++;
        if (bus.paddle_y !== 10'd212) begin
            n_bad++;
            $display("FAIL post_reset_tick2 got y=%0d want y=212", bus.paddle_y);
        end
        bus.down = 1'b0;
    endtask

    initial begin
        test_reset();
        test_accel();
        test_wall_top();
        test_wall_bottom();
        test_both_and_center();
        test_reset_mid_move();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
